// File: rtl/gate_vector_checker.sv
// Drives the four input vectors of a 2-input gate under test, checks each response against a truth table.
// Latency 4*(HOLD_CYCLES+1) clocks from start to done; start is ignored while a run is in progress.
module gate_vector_checker #(
   parameter int          HOLD_CYCLES = 2,
   parameter logic [3:0]  EXPECT_TT   = 4'b0111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       in1,
   output logic       in2,
   input  logic       gate_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [1:0] vec_idx
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] hold_cnt;
   logic       mismatch;
   logic [2:0] err_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:   if (start) state_nxt = DRIVE;
         DRIVE: begin
            busy = 1'b1;
            if (hold_cnt == 4'd0) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            busy      = 1'b1;
            state_nxt = (vec_idx == 2'd3) ? FINISH : DRIVE;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   assign {in1, in2} = busy ? vec_idx : 2'b00;

   // Case inequality so an X/Z response from the gate is scored as a mismatch.
   assign mismatch = (state == SAMPLE) && (gate_out !== EXPECT_TT[vec_idx]);
   assign err_nxt  = (mismatch && (err_cnt != 3'd4)) ? err_cnt + 3'd1 : err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= 4'd0;
         vec_idx  <= 2'd0;
         err_cnt  <= 3'd0;
         pass     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  vec_idx  <= 2'd0;
                  err_cnt  <= 3'd0;
                  pass     <= 1'b0;
                  hold_cnt <= HOLD_LOAD;
               end
            end
            DRIVE: begin
               if (hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;
            end
            SAMPLE: begin
               err_cnt <= err_nxt;
               if (vec_idx == 2'd3) begin
                  pass <= (err_nxt == 3'd0);
               end else begin
                  vec_idx  <= vec_idx + 2'd1;
                  hold_cnt <= HOLD_LOAD;
               end
            end
            FINISH: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: two checker instances (hold 2 and hold 1) each driving a behavioural gate model.
module tb_gate_vector_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start0 = 1'b0, start1 = 1'b0;
   int         mode0 = 0, mode1 = 0;   // 0 = NAND, 1 = AND, 2 = stuck at 1
   logic       a0, b0, g0, busy0, done0, pass0;
   logic       a1, b1, g1, busy1, done1, pass1;
   logic [2:0] err0, err1;
   logic [1:0] vi0, vi1;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   function automatic logic gate_model(int m, logic a, logic b);
      case (m)
         1:       return a & b;
         2:       return 1'b1;
         default: return ~(a & b);
      endcase
   endfunction

   assign g0 = gate_model(mode0, a0, b0);
   assign g1 = gate_model(mode1, a1, b1);

   gate_vector_checker #(.HOLD_CYCLES(2), .EXPECT_TT(4'b0111)) dut (
      .clk(clk), .rst_n(rst_n), .start(start0), .in1(a0), .in2(b0), .gate_out(g0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .vec_idx(vi0));

   gate_vector_checker #(.HOLD_CYCLES(1), .EXPECT_TT(4'b0111)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .in1(a1), .in2(b1), .gate_out(g1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .vec_idx(vi1));

   // Leaves the bench at the falling edge just after the edge that sampled start (k = 0).
   task automatic pulse_start0();
      @(negedge clk); start0 = 1'b1;
      @(posedge clk);
      @(negedge clk); start0 = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({a0, b0, busy0, done0, pass0, err0, vi0} !== 10'b0) begin
         errors++;
         $display("FAIL reset_dut0 got %b want 0", {a0, b0, busy0, done0, pass0, err0, vi0});
      end
      checks++;
      if ({a1, b1, busy1, done1, pass1, err1, vi1} !== 10'b0) begin
         errors++;
         $display("FAIL reset_dut1 got %b want 0", {a1, b1, busy1, done1, pass1, err1, vi1});
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_nand_pass();
      logic [3:0] exp_o;
      mode0 = 0;
      pulse_start0();
      for (int k = 0; k <= 12; k++) begin
         exp_o = (k < 12) ? {2'(k / 3), 1'b1, 1'b0} : 4'b0001;
         checks++;
         if ({a0, b0, busy0, done0} !== exp_o) begin
            errors++;
            $display("FAIL nand_seq k=%0d got %b want %b", k, {a0, b0, busy0, done0}, exp_o);
         end
         @(negedge clk);
      end
      checks++;
      if ({busy0, done0, pass0, err0} !== 6'b001_000) begin
         errors++;
         $display("FAIL nand_verdict got %b want 001000", {busy0, done0, pass0, err0});
      end
   endtask

   task automatic test_and_mismatch();
      logic [2:0] exp_e;
      mode0 = 1;
      pulse_start0();
      checks++;
      if ({pass0, err0} !== 4'b0) begin
         errors++;
         $display("FAIL and_start_clear got %b want 0000", {pass0, err0});
      end
      for (int k = 0; k <= 12; k++) begin
         exp_e = 3'(k / 3);
         checks++;
         if ({done0, err0} !== {(k == 12), exp_e}) begin
            errors++;
            $display("FAIL and_err k=%0d got %b want %b", k, {done0, err0}, {(k == 12), exp_e});
         end
         @(negedge clk);
      end
      checks++;
      if ({done0, pass0, err0} !== 5'b00_100) begin
         errors++;
         $display("FAIL and_verdict got %b want 00100", {done0, pass0, err0});
      end
   endtask

   task automatic test_stuck_one();
      mode0 = 2;
      pulse_start0();
      for (int k = 0; k <= 12; k++) begin
         if (k == 11 || k == 12) begin
            checks++;
            if ({done0, pass0, err0} !== {(k == 12), 1'b0, (k == 12) ? 3'd1 : 3'd0}) begin
               errors++;
               $display("FAIL stuck_err k=%0d got %b", k, {done0, pass0, err0});
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_midrun();
      mode0 = 1;
      pulse_start0();
      repeat (7) @(negedge clk);
      checks++;
      if ({a0, b0, err0} !== 5'b10_010) begin
         errors++;
         $display("FAIL midrun_pre got %b want 10010", {a0, b0, err0});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a0, b0, busy0, done0, pass0, err0, vi0} !== 10'b0) begin
         errors++;
         $display("FAIL midrun_async got %b want 0", {a0, b0, busy0, done0, pass0, err0, vi0});
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({busy0, done0} !== 2'b00) begin
         errors++;
         $display("FAIL midrun_held got %b want 00", {busy0, done0});
      end
      mode0 = 0;
      rst_n = 1'b1;
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk); start0 = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         if (k == 0 || k >= 11) begin
            checks++;
            if ({busy0, done0} !== {(k < 12), (k == 12)}) begin
               errors++;
               $display("FAIL rerun_ctl k=%0d got %b", k, {busy0, done0});
            end
         end
         @(negedge clk);
      end
      checks++;
      if ({pass0, err0} !== 4'b1000) begin
         errors++;
         $display("FAIL rerun_verdict got %b want 1000", {pass0, err0});
      end
   endtask

   task automatic test_start_held();
      logic [3:0] exp_o;
      mode1 = 1;
      @(negedge clk); start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k <= 8; k++) begin
         exp_o = (k < 8) ? {2'(k / 2), 1'b1, 1'b0} : 4'b0001;
         checks++;
         if ({a1, b1, busy1, done1} !== exp_o) begin
            errors++;
            $display("FAIL held_seq k=%0d got %b want %b", k, {a1, b1, busy1, done1}, exp_o);
         end
         @(negedge clk);
      end
      mode1 = 0;
      checks++;
      if ({busy1, done1, pass1, err1} !== 6'b000_100) begin
         errors++;
         $display("FAIL held_idle got %b want 000100", {busy1, done1, pass1, err1});
      end
      @(negedge clk);
      checks++;
      if ({a1, b1, busy1, done1, pass1, err1} !== 8'b00_10_0000) begin
         errors++;
         $display("FAIL held_restart got %b want 00100000", {a1, b1, busy1, done1, pass1, err1});
      end
      start1 = 1'b0;
      for (int k = 11; k <= 18; k++) begin
         @(negedge clk);
         if (k >= 17) begin
            checks++;
            if ({done1, pass1} !== {(k == 18), (k == 18)}) begin
               errors++;
               $display("FAIL held_second k=%0d got %b", k, {done1, pass1});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_nand_pass();
      test_and_mismatch();
      test_stuck_one();
      test_reset_midrun();
      test_start_held();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
